input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Front-end stage that feeds the CPU's Din, Sample and Btns inputs from raw board pins.
//  - Synchronises the 8 slide switches and the 4 push-buttons into the Clock domain.
//  - Debounces the 4 push-buttons.
//  - On a Sample-button press, latches the switch value into Din and raises Sample.
//  - Holds Sample high until the slow-ticking CPU has had time to see it.
// PARAMETERS
//  DEB_CYCLES    500000    cycles a raw button must differ from its stable level before it is accepted
//  CNT_W         20        width of each debounce counter; must satisfy 2**CNT_W > DEB_CYCLES
//  STRETCH       12500001  cycles Sample stays high after a press; 0 = hold until SampleAck
//  STR_W         24        width of the stretch counter; must satisfy 2**STR_W > STRETCH
//  REP_DELAY     25000000  cycles before the first auto-repeat (AUTO_REPEAT_EN only)
//  REP_PERIOD    12500000  cycles between later auto-repeats (AUTO_REPEAT_EN only)
// PORTS
//  Clock      in   1  system clock
//  Reset      in   1  asynchronous, active-low reset
//  SwRaw      in   8  raw slide switches, asynchronous to Clock
//  BtnRaw     in   4  raw buttons: [3] = Sample button, [2:0] = user buttons
//  SampleAck  in   1  single-cycle acknowledge from the consumer; tie 0 if unused
//  Din        out  8  latched switch value, stable while Sample is high
//  Sample     out  1  sample-valid level
//  Btns       out  3  debounced levels of BtnRaw[2:0]
//  Overrun    out  1  sticky: a new press arrived while Sample was still high
// BEHAVIOUR
//  Reset (Reset=0, asynchronous):
//  - Din=0, Sample=0, Btns=0, Overrun=0.
//  - All synchroniser flops, stable levels and counters clear to 0.
//  Synchronisation:
//  - Each SwRaw and BtnRaw bit passes through a 2-flop synchroniser.
//  - Switch bits are synchronised only, not debounced.
//  Debounce, per button channel (4 independent instances):
//  - State is a stable level plus a counter cnt.
//  - If sync == stable: cnt <= 0.
//  - Else if cnt == DEB_CYCLES-1: stable <= sync and cnt <= 0.
//  - Else: cnt <= cnt+1.
//  - A glitch shorter than DEB_CYCLES cycles never changes the stable level.
//  - Btns = stable[2:0], registered.
//  - Latency from a raw edge to a Btns change is 2 + DEB_CYCLES cycles.
//  Sample FSM, states IDLE and VALID:
//  - Press = 1-cycle rising edge of stable[3].
//  - IDLE, on press:
//    - Din <= synchronised switches from the same cycle.
//    - Sample <= 1; scnt <= STRETCH; go to VALID.
//  - VALID, on press:
//    - Din re-latched, scnt reloaded, Overrun <= 1; stay in VALID.
//  - VALID, otherwise:
//    - On SampleAck, or (STRETCH != 0 and scnt == 1): Sample <= 0 and go to IDLE.
//    - Otherwise, if STRETCH != 0: scnt <= scnt-1.
//  - Press and SampleAck in the same cycle: the press wins and Sample stays 1.
//  - SampleAck while in IDLE is ignored.
//  - Din changes only on a press, never while Sample is high unless a new press occurs.
//  - Overrun clears only on reset.
//  - Button release (falling edge of stable[3]) has no effect on Sample.
//  Reset mid-operation:
//  - Sample drops immediately.
//  - A press still held when reset deasserts is treated as a fresh press only after it
//    debounces from 0 to 1.
// CONFIGURATION
//  Macro AUTO_REPEAT_EN.
//  When defined:
//  - While stable[3] is held, a repeat press is generated REP_DELAY cycles after the
//    original press, then every REP_PERIOD cycles.
//  - A repeat press behaves exactly like a real press: it re-latches Din and sets
//    Overrun if Sample is still high.
//  - The repeat counter clears on release or reset.
//  When undefined:
//  - No repeat counter exists; one press gives exactly one sample.
// TESTING
//  (bench parameters: DEB_CYCLES=8, STRETCH=20)
//  1. Reset=0 with all inputs toggling -> Din=0, Sample=0, Btns=0, Overrun=0 throughout.
//  2. BtnRaw[0] glitch high for 5 cycles -> Btns[0] stays 0.
//     BtnRaw[0] held high -> Btns[0]=1 exactly 10 cycles after the raw edge.
//  3. SwRaw=8'hA5, press BtnRaw[3] -> Din=8'hA5, Sample=1 for 20 cycles, then 0.
//     Changing SwRaw to 8'h3C during those 20 cycles leaves Din=8'hA5.
//  4. Press, then SampleAck on the 3rd cycle of Sample -> Sample=0 next cycle; Overrun=0.
//  5. Second press while Sample is high, with SwRaw=8'h7F ->
//     Din=8'h7F, stretch restarts, Overrun=1 until reset.
//  6. AUTO_REPEAT_EN with REP_DELAY=40, REP_PERIOD=30, button held 120 cycles after its
//     press -> Sample rises at press+0, +40, +70 and +100.
//     With the macro undefined, the same stimulus gives a single rise.

Source files
------------

// File: rtl/input_conditioner.sv
// Board-pin front end: synchronises switches and buttons, debounces buttons and
// produces a stretched Sample pulse. Optional auto-repeat under `AUTO_REPEAT_EN.
//
// state | meaning
// IDLE  | no sample pending, Sample low
// VALID | Din holds a latched value, Sample high until stretch expiry or SampleAck
module input_conditioner #(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 20,
  parameter int STRETCH    = 12500001,
  parameter int STR_W      = 24,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 12500000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] SwRaw,
  input  logic [3:0] BtnRaw,
  input  logic       SampleAck,
  output logic [7:0] Din,
  output logic       Sample,
  output logic [2:0] Btns,
  output logic       Overrun
);

  typedef enum logic {IDLE, VALID} state_t;

  logic [7:0]            sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [3:0]            btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [3:0]            stable_q, stable_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  state_t                state_q, state_d;
  logic [7:0]            din_q, din_d;
  logic [STR_W-1:0]      scnt_q, scnt_d;
  logic                  ovr_q, ovr_d;
  logic                  press_real, rep_fire, press;

  always_comb begin
    sw_s1_d  = SwRaw;
    sw_s2_d  = sw_s1_q;
    btn_s1_d = BtnRaw;
    btn_s2_d = btn_s1_q;
  end

  // A channel flips only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (btn_s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) begin
        stable_d[i] = btn_s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign press_real = stable_d[3] & ~stable_q[3];

`ifdef AUTO_REPEAT_EN
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_q, rep_d;

  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (press_real) begin
      rep_d = REP_W'(REP_DELAY);
    end else if (!stable_q[3]) begin
      rep_d = '0;
    end else if (rep_q == REP_W'(1)) begin
      rep_fire = 1'b1;
      rep_d    = REP_W'(REP_PERIOD);
    end else if (rep_q != '0) begin
      rep_d = rep_q - REP_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign press = press_real | rep_fire;

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    scnt_d  = scnt_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (press) begin
          din_d   = sw_s2_q;
          scnt_d  = STR_W'(STRETCH);
          state_d = VALID;
        end
      end
      VALID: begin
        // A press outranks a simultaneous acknowledge.
        if (press) begin
          din_d  = sw_s2_q;
          scnt_d = STR_W'(STRETCH);
          ovr_d  = 1'b1;
        end else if (SampleAck || (STRETCH != 0 && scnt_q == STR_W'(1))) begin
          state_d = IDLE;
        end else if (STRETCH != 0) begin
          scnt_d = scnt_q - STR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      din_q    <= '0;
      scnt_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      din_q    <= din_d;
      scnt_q   <= scnt_d;
      ovr_q    <= ovr_d;
    end
  end

  assign Din     = din_q;
  assign Sample  = (state_q == VALID);
  assign Btns    = stable_q[2:0];
  assign Overrun = ovr_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random stimulus, all
// checked every cycle against a timestamp-based behavioural model.
module tb_input_conditioner;

  localparam int DEB        = 8;
  localparam int STRETCH    = 20;
  localparam int REP_DELAY  = 40;
  localparam int REP_PERIOD = 30;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] SwRaw;
  logic [3:0] BtnRaw;
  logic       SampleAck;
  logic [7:0] Din;
  logic       Sample;
  logic [2:0] Btns;
  logic       Overrun;

  int n_total = 0;
  int n_bad   = 0;

  input_conditioner #(
    .DEB_CYCLES(DEB), .CNT_W(4), .STRETCH(STRETCH), .STR_W(5),
    .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)
  ) dut (
    .Clock(Clock), .Reset(Reset), .SwRaw(SwRaw), .BtnRaw(BtnRaw),
    .SampleAck(SampleAck), .Din(Din), .Sample(Sample), .Btns(Btns),
    .Overrun(Overrun)
  );

  always #5 Clock = ~Clock;

  // Model: edge counter, per-channel time of last debounce restart, and
  // absolute edge numbers for stretch expiry and press time.
  int         m_e;
  int         m_last_rst[4];
  int         m_fall_at;
  int         m_press_at;
  logic [7:0] m_sw1, m_sw2, m_din;
  logic [3:0] m_b1, m_b2, m_stable;
  bit         m_valid, m_ovr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_e = 0; m_fall_at = 0; m_press_at = 0;
    m_sw1 = '0; m_sw2 = '0; m_din = '0;
    m_b1 = '0; m_b2 = '0; m_stable = '0;
    m_valid = 0; m_ovr = 0;
    for (int i = 0; i < 4; i++) m_last_rst[i] = 0;
  endtask

  task automatic model_step();
    logic [3:0] old_st;
    bit real_p, rep_p;
    m_e++;
    old_st = m_stable;
    for (int i = 0; i < 4; i++) begin
      if (m_b2[i] == old_st[i]) m_last_rst[i] = m_e;
      else if (m_e - m_last_rst[i] >= DEB) begin
        m_stable[i]   = m_b2[i];
        m_last_rst[i] = m_e;
      end
    end
    real_p = m_stable[3] && !old_st[3];
    rep_p  = 0;
`ifdef AUTO_REPEAT_EN
    if (old_st[3] && (m_e - m_press_at) >= REP_DELAY &&
        ((m_e - m_press_at - REP_DELAY) % REP_PERIOD) == 0)
      rep_p = 1;
`endif
    if (real_p) m_press_at = m_e;
    if (real_p || rep_p) begin
      if (m_valid) m_ovr = 1;
      m_din     = m_sw2;
      m_valid   = 1;
      m_fall_at = m_e + STRETCH;
    end else if (m_valid && (SampleAck || m_e == m_fall_at)) begin
      m_valid = 0;
    end
    m_sw2 = m_sw1; m_sw1 = SwRaw;
    m_b2  = m_b1;  m_b1  = BtnRaw;
  endtask

  task automatic check_model();
    check_eq("din", Din, m_din);
    check_eq("sample", Sample, m_valid);
    check_eq("btns", Btns, m_stable[2:0]);
    check_eq("overrun", Overrun, m_ovr);
  endtask

  task automatic tick();
    @(posedge Clock);
    if (Reset) model_step();
    #1;
    check_model();
  endtask

  int rises[$];
  int exp_rises[$];
  logic prev_s;

  initial begin
    Reset = 1'b0; SwRaw = '0; BtnRaw = '0; SampleAck = 1'b0;
    model_reset();

    // 1: reset held with inputs toggling
    for (int c = 0; c < 20; c++) begin
      SwRaw = 8'($urandom); BtnRaw = 4'($urandom); SampleAck = 1'($urandom);
      tick();
    end
    SwRaw = '0; BtnRaw = '0; SampleAck = 1'b0;
    Reset = 1'b1;
    repeat (4) tick();

    // 2: glitch rejection and debounce latency
    BtnRaw[0] = 1'b1;
    repeat (5) tick();
    BtnRaw[0] = 1'b0;
    repeat (15) tick();
    check_eq("glitch_btn0", Btns[0], 1'b0);
    BtnRaw[0] = 1'b1;
    repeat (9) tick();
    check_eq("lat9_btn0", Btns[0], 1'b0);
    tick();
    check_eq("lat10_btn0", Btns[0], 1'b1);
    BtnRaw[0] = 1'b0;
    repeat (12) tick();

    // 3: latch and stretch
    SwRaw = 8'hA5;
    repeat (3) tick();
    BtnRaw[3] = 1'b1;
    repeat (10) tick();
    check_eq("s3_rise", Sample, 1'b1);
    check_eq("s3_din", Din, 8'hA5);
    BtnRaw[3] = 1'b0;
    SwRaw = 8'h3C;
    repeat (19) tick();
    check_eq("s3_hold", Sample, 1'b1);
    check_eq("s3_din_stable", Din, 8'hA5);
    tick();
    check_eq("s3_fall", Sample, 1'b0);
    repeat (15) tick();

    // 4: early acknowledge
    SwRaw = 8'h11;
    BtnRaw[3] = 1'b1;
    repeat (10) tick();
    check_eq("s4_rise", Sample, 1'b1);
    BtnRaw[3] = 1'b0;
    repeat (2) tick();
    SampleAck = 1'b1;
    tick();
    SampleAck = 1'b0;
    check_eq("s4_ack_fall", Sample, 1'b0);
    check_eq("s4_overrun", Overrun, 1'b0);
    repeat (15) tick();

    // 5: second press while Sample still high
    SwRaw = 8'h22;
    BtnRaw[3] = 1'b1;
    repeat (10) tick();
    check_eq("s5_rise", Sample, 1'b1);
    BtnRaw[3] = 1'b0;
    repeat (9) tick();
    SwRaw = 8'h7F;
    BtnRaw[3] = 1'b1;
    repeat (10) tick();
    check_eq("s5_sample", Sample, 1'b1);
    check_eq("s5_din", Din, 8'h7F);
    check_eq("s5_overrun", Overrun, 1'b1);
    BtnRaw[3] = 1'b0;
    repeat (19) tick();
    check_eq("s5_restart_hold", Sample, 1'b1);
    tick();
    check_eq("s5_restart_fall", Sample, 1'b0);
    repeat (25) tick();
    check_eq("s5_overrun_sticky", Overrun, 1'b1);

    // 6: long hold; repeats only with AUTO_REPEAT_EN
`ifdef AUTO_REPEAT_EN
    exp_rises = '{0, 40, 70, 100};
`else
    exp_rises = '{0};
`endif
    BtnRaw[3] = 1'b1;
    prev_s = Sample;
    for (int c = 1; c <= 150; c++) begin
      if (c == 115) BtnRaw[3] = 1'b0;
      tick();
      if (Sample && !prev_s) rises.push_back(c - 10);
      prev_s = Sample;
    end
    check_eq("rep_count", rises.size(), exp_rises.size());
    for (int i = 0; i < rises.size() && i < exp_rises.size(); i++)
      check_eq("rep_offset", rises[i], exp_rises[i]);

    // random stimulus
    for (int seg = 0; seg < 80; seg++) begin
      int len;
      SwRaw  = 8'($urandom);
      BtnRaw = BtnRaw ^ 4'($urandom);
      len    = $urandom_range(1, 25);
      for (int c = 0; c < len; c++) begin
        SampleAck = ($urandom_range(0, 7) == 0);
        tick();
      end
    end
    SampleAck = 1'b0;
    BtnRaw = '0;
    repeat (30) tick();

    // reset mid-operation with Sample button held
    SwRaw = 8'h5A;
    BtnRaw[3] = 1'b1;
    repeat (10) tick();
    check_eq("rst_pre_sample", Sample, 1'b1);
    repeat (3) tick();
    #2 Reset = 1'b0;
    model_reset();
    #1;
    check_eq("rst_sample", Sample, 1'b0);
    check_eq("rst_din", Din, 8'h00);
    check_eq("rst_overrun", Overrun, 1'b0);
    check_eq("rst_btns", Btns, 3'b000);
    repeat (4) tick();
    Reset = 1'b1;
    repeat (9) tick();
    check_eq("rst_no_early_press", Sample, 1'b0);
    tick();
    check_eq("rst_fresh_press", Sample, 1'b1);
    check_eq("rst_fresh_din", Din, 8'h5A);
    BtnRaw[3] = 1'b0;
    repeat (25) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
